// File: rtl/ea_sequencer_if.sv
// Byte-read pointer-fetch port between ea_sequencer (master) and the memory arbiter (slave).
interface ea_sequencer_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_ready;

   modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ready);
   modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ready);
endinterface

// File: rtl/ea_sequencer.sv
// 6502 effective-address sequencer: direct modes in one CALC cycle, indirect modes via pointer
// fetches with a wait-state timeout. Define JMP_IND_BUG_EN for the NMOS JMP (ind) page-wrap bug.
module ea_sequencer #(
   parameter logic [7:0]  ZP_PAGE = 8'h00,
   parameter int unsigned WAIT_TO = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [3:0]     addr_mode,
   input  logic [7:0]     operand_lo,
   input  logic [7:0]     operand_hi,
   input  logic [7:0]     X_reg,
   input  logic [7:0]     Y_reg,
   input  logic [15:0]    PC_in,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [15:0]    eff_addr,
   output logic           page_crossed,
   ea_sequencer_if.master mem
);
   localparam logic [3:0] ModeImm  = 4'd0;
   localparam logic [3:0] ModeZp   = 4'd1;
   localparam logic [3:0] ModeZpx  = 4'd2;
   localparam logic [3:0] ModeZpy  = 4'd3;
   localparam logic [3:0] ModeAbs  = 4'd4;
   localparam logic [3:0] ModeAbsx = 4'd5;
   localparam logic [3:0] ModeAbsy = 4'd6;
   localparam logic [3:0] ModeInd  = 4'd7;
   localparam logic [3:0] ModeIndx = 4'd8;
   localparam logic [3:0] ModeIndy = 4'd9;
   localparam logic [3:0] ModeRel  = 4'd10;
   localparam logic [7:0] WaitLast = 8'(WAIT_TO - 1);

   typedef enum logic [2:0] {StIdle, StCalc, StPtrLo, StPtrHi, StFin} state_e;

   state_e      state_q;
   logic [3:0]  mode_q;
   logic [7:0]  lo_q, hi_q, x_q, y_q;
   logic [15:0] pc_q;
   logic [7:0]  ptr_lo_q, ptr_hi_q;
   logic [7:0]  wait_cnt_q;
   logic [15:0] calc_addr;
   logic        calc_cross;

   // Address of the low (second=0) or high (second=1) pointer byte.
   function automatic logic [15:0] ptr_addr(input logic [3:0] mode, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic [7:0] x,
                                            input logic second);
      logic [7:0]  zp;
      logic [15:0] addr;
      zp = (mode == ModeIndx) ? lo + x : lo;
      if (mode == ModeInd) begin
         if (!second) begin
            addr = {hi, lo};
         end else begin
`ifdef JMP_IND_BUG_EN
            addr = {hi, lo + 8'd1};
`else
            addr = {hi, lo} + 16'd1;
`endif
         end
      end else begin
         addr = {ZP_PAGE, second ? zp + 8'd1 : zp};
      end
      return addr;
   endfunction

   always_comb begin
      calc_addr  = 16'h0000;
      calc_cross = 1'b0;
      case (mode_q)
         ModeImm: calc_addr = pc_q + 16'd1;
         ModeZp:  calc_addr = {ZP_PAGE, lo_q};
         ModeZpx: calc_addr = {ZP_PAGE, lo_q + x_q};
         ModeZpy: calc_addr = {ZP_PAGE, lo_q + y_q};
         ModeAbs: calc_addr = {hi_q, lo_q};
         ModeAbsx: begin
            calc_addr  = {hi_q, lo_q} + {8'h00, x_q};
            calc_cross = calc_addr[15:8] != hi_q;
         end
         ModeAbsy: begin
            calc_addr  = {hi_q, lo_q} + {8'h00, y_q};
            calc_cross = calc_addr[15:8] != hi_q;
         end
         ModeInd, ModeIndx: calc_addr = {ptr_hi_q, ptr_lo_q};
         ModeIndy: begin
            calc_addr  = {ptr_hi_q, ptr_lo_q} + {8'h00, y_q};
            calc_cross = calc_addr[15:8] != ptr_hi_q;
         end
         ModeRel: begin
            calc_addr  = pc_q + {{8{lo_q[7]}}, lo_q};
            calc_cross = calc_addr[15:8] != pc_q[15:8];
         end
         default: calc_addr = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         eff_addr     <= 16'h0000;
         page_crossed <= 1'b0;
         mem.mem_addr <= 16'h0000;
         mem.mem_rd   <= 1'b0;
         mode_q       <= 4'd0;
         lo_q         <= 8'h00;
         hi_q         <= 8'h00;
         x_q          <= 8'h00;
         y_q          <= 8'h00;
         pc_q         <= 16'h0000;
         ptr_lo_q     <= 8'h00;
         ptr_hi_q     <= 8'h00;
         wait_cnt_q   <= 8'h00;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  mode_q <= addr_mode;
                  lo_q   <= operand_lo;
                  hi_q   <= operand_hi;
                  x_q    <= X_reg;
                  y_q    <= Y_reg;
                  pc_q   <= PC_in;
                  busy   <= 1'b1;
                  if (addr_mode inside {ModeInd, ModeIndx, ModeIndy}) begin
                     mem.mem_addr <= ptr_addr(addr_mode, operand_lo, operand_hi, X_reg, 1'b0);
                     mem.mem_rd   <= 1'b1;
                     wait_cnt_q   <= 8'h00;
                     state_q      <= StPtrLo;
                  end else begin
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               eff_addr     <= calc_addr;
               page_crossed <= calc_cross;
               done         <= 1'b1;
               state_q      <= StFin;
            end
            StPtrLo, StPtrHi: begin
               // A completing read beats a timeout landing on the same cycle.
               if (mem.mem_ready) begin
                  wait_cnt_q <= 8'h00;
                  if (state_q == StPtrLo) begin
                     ptr_lo_q     <= mem.mem_rdata;
                     mem.mem_addr <= ptr_addr(mode_q, lo_q, hi_q, x_q, 1'b1);
                     state_q      <= StPtrHi;
                  end else begin
                     ptr_hi_q   <= mem.mem_rdata;
                     mem.mem_rd <= 1'b0;
                     state_q    <= StCalc;
                  end
               end else if (wait_cnt_q == WaitLast) begin
                  mem.mem_rd   <= 1'b0;
                  eff_addr     <= 16'h0000;
                  page_crossed <= 1'b0;
                  done         <= 1'b1;
                  err          <= 1'b1;
                  state_q      <= StFin;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            StFin: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_ea_sequencer.sv
// Directed bench for ea_sequencer: transaction-level model plus a per-cycle compare process.
module tb_ea_sequencer;
   localparam int unsigned WaitTo = 16;
   localparam logic [7:0]  ZpPage = 8'h00;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  addr_mode = 4'd0;
   logic [7:0]  operand_lo = 8'h00, operand_hi = 8'h00, X_reg = 8'h00, Y_reg = 8'h00;
   logic [15:0] PC_in = 16'h0000;
   logic        busy, done, err, page_crossed;
   logic [15:0] eff_addr;

   ea_sequencer_if mem_bus ();

   ea_sequencer #(.ZP_PAGE(ZpPage), .WAIT_TO(WaitTo)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .addr_mode(addr_mode),
      .operand_lo(operand_lo), .operand_hi(operand_hi), .X_reg(X_reg), .Y_reg(Y_reg),
      .PC_in(PC_in), .busy(busy), .done(done), .err(err), .eff_addr(eff_addr),
      .page_crossed(page_crossed), .mem(mem_bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [0:65535];

   // Transaction expectations, written by the driver only.
   bit          act = 1'b0;
   int          t0 = -100, dn = 0, rd_last = 0, nrd = 0, ra0 = 0, ra1 = 0;
   bit          tmo = 1'b0;
   logic [15:0] new_eff = 16'h0000, lit_ea = 16'h0000;
   logic        new_pc = 1'b0, lit_pc = 1'b0;
   int          wait_cfg = 0;

   // Owned by the compare process.
   int          n_chk = 0, n_err = 0;
   logic [15:0] held_eff = 16'h0000;
   logic        held_pc = 1'b0;
   int          dead_t0 = -1;
   bit          rst_prev = 1'b0;
   bit          last_rd = 1'b0, last_rdy = 1'b0;
   logic [15:0] last_addr = 16'h0000;
   int          waited = 0;
   logic [15:0] rd_log [$];

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Expected result from the addressing rules, as plain integer arithmetic.
   function automatic void model(input int mode, input int lo, input int hi, input int x,
                                 input int y, input int pc, output int ea, output int pcr,
                                 output int n, output int a0, output int a1);
      int zp, p, ptr, off;
      zp = int'(ZpPage);
      ea = 0; pcr = 0; n = 0; a0 = 0; a1 = 0;
      case (mode)
         0: ea = (pc + 1) % 65536;
         1: ea = zp * 256 + lo;
         2: ea = zp * 256 + (lo + x) % 256;
         3: ea = zp * 256 + (lo + y) % 256;
         4: ea = hi * 256 + lo;
         5, 6: begin
            ea  = (hi * 256 + lo + ((mode == 5) ? x : y)) % 65536;
            pcr = (ea / 256 != hi) ? 1 : 0;
         end
         7: begin
            n  = 2;
            a0 = hi * 256 + lo;
`ifdef JMP_IND_BUG_EN
            a1 = hi * 256 + (lo + 1) % 256;
`else
            a1 = (a0 + 1) % 65536;
`endif
            ea = int'(mem[a1]) * 256 + int'(mem[a0]);
         end
         8: begin
            n  = 2;
            p  = (lo + x) % 256;
            a0 = zp * 256 + p;
            a1 = zp * 256 + (p + 1) % 256;
            ea = int'(mem[a1]) * 256 + int'(mem[a0]);
         end
         9: begin
            n   = 2;
            a0  = zp * 256 + lo;
            a1  = zp * 256 + (lo + 1) % 256;
            ptr = int'(mem[a1]) * 256 + int'(mem[a0]);
            ea  = (ptr + y) % 65536;
            pcr = (ea / 256 != int'(mem[a1])) ? 1 : 0;
         end
         10: begin
            off = (lo >= 128) ? lo - 256 : lo;
            ea  = (pc + off + 65536) % 65536;
            pcr = (ea / 256 != pc / 256) ? 1 : 0;
         end
         default: ea = 0;
      endcase
   endfunction

   // Per-cycle compare plus the wait-stated memory responder.
   always @(negedge clk) begin
      int r;
      bit live;
      logic rdy;
      if (rst_prev) begin
         held_eff = 16'h0000;
         held_pc  = 1'b0;
         dead_t0  = t0;
         rd_log.delete();
         chk("reset_mem_addr", mem_bus.mem_addr, 16'h0000);
      end
      rst_prev = !reset_n;
      live = act && (t0 != dead_t0);
      r = cyc - t0;
      if (live && r == dn) begin
         held_eff = new_eff;
         held_pc  = new_pc;
         chk("literal_eff_addr", eff_addr, lit_ea);
         chk("literal_page_crossed", {15'd0, page_crossed}, {15'd0, lit_pc});
         chk("read_count", 16'(rd_log.size()), 16'(nrd));
         if (nrd == 2 && rd_log.size() == 2) begin
            chk("read_addr_lo", rd_log[0], 16'(ra0));
            chk("read_addr_hi", rd_log[1], 16'(ra1));
         end
         rd_log.delete();
      end
      chk("busy", {15'd0, busy}, {15'd0, live && r >= 1 && r <= dn});
      chk("done", {15'd0, done}, {15'd0, live && r == dn});
      chk("err", {15'd0, err}, {15'd0, live && r == dn && tmo});
      chk("mem_rd", {15'd0, mem_bus.mem_rd}, {15'd0, live && r >= 1 && r <= rd_last});
      chk("eff_addr", eff_addr, held_eff);
      chk("page_crossed", {15'd0, page_crossed}, {15'd0, held_pc});
      if (mem_bus.mem_rd && last_rd && !last_rdy)
         chk("mem_addr_stable", mem_bus.mem_addr, last_addr);

      rdy = 1'b0;
      if (mem_bus.mem_rd) begin
         if (!last_rd || last_rdy) waited = 0;
         if (waited >= wait_cfg) begin
            rdy = 1'b1;
            mem_bus.mem_rdata = mem[mem_bus.mem_addr];
            rd_log.push_back(mem_bus.mem_addr);
         end else begin
            waited++;
         end
      end
      mem_bus.mem_ready = rdy;
      last_rd   = mem_bus.mem_rd;
      last_addr = mem_bus.mem_addr;
      last_rdy  = rdy;
   end

   task automatic run_txn(input int mode, input int lo, input int hi, input int x, input int y,
                          input int pc, input int w, input int poke, input int rst_at,
                          input int lit_e, input int lit_p);
      int ea, pcr, n, a0, a1;
      bit ind;
      @(posedge clk); #1;
      addr_mode  = 4'(mode);
      operand_lo = 8'(lo);
      operand_hi = 8'(hi);
      X_reg      = 8'(x);
      Y_reg      = 8'(y);
      PC_in      = 16'(pc);
      wait_cfg   = w;
      start      = 1'b1;
      model(mode, lo, hi, x, y, pc, ea, pcr, n, a0, a1);
      ind = (mode >= 7 && mode <= 9);
      tmo = ind && (w >= int'(WaitTo));
      if (!ind) begin
         dn = 2; rd_last = 0;
      end else if (tmo) begin
         dn = int'(WaitTo) + 1; rd_last = int'(WaitTo);
         ea = 0; pcr = 0; n = 0;
      end else begin
         dn = 4 + 2 * w; rd_last = 2 + 2 * w;
      end
      new_eff = 16'(ea);
      new_pc  = (pcr != 0);
      nrd     = n;
      ra0     = a0;
      ra1     = a1;
      lit_ea  = 16'(lit_e);
      lit_pc  = (lit_p != 0);
      t0      = cyc;
      act     = 1'b1;
      for (int i = 1; i <= dn; i++) begin
         @(posedge clk); #1;
         if (i == rst_at) begin
            start   = 1'b0;
            reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            break;
         end
         start = (i == poke);
         if (i == poke) begin
            addr_mode  = 4'd4;
            operand_lo = ~operand_lo;
            operand_hi = ~operand_hi;
            X_reg      = 8'hAA;
            Y_reg      = 8'h55;
            PC_in      = ~PC_in;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
      mem[16'h00FF] = 8'hFE;
      mem[16'h0000] = 8'h30;
      mem[16'h02FF] = 8'h34;
      mem[16'h0200] = 8'h12;
      mem[16'h0300] = 8'h56;
      mem[16'h0015] = 8'h78;
      mem[16'h0016] = 8'h9A;

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      run_txn(5, 8'hF0, 8'h12, 8'h20, 0, 0, 0, 0, 0, 16'h1310, 1);
      run_txn(9, 8'hFF, 0, 0, 8'h05, 0, 0, 0, 0, 16'h3103, 1);
`ifdef JMP_IND_BUG_EN
      run_txn(7, 8'hFF, 8'h02, 0, 0, 0, 1, 0, 0, 16'h1234, 0);
`else
      run_txn(7, 8'hFF, 8'h02, 0, 0, 0, 1, 0, 0, 16'h5634, 0);
`endif
      run_txn(8, 8'h40, 0, 0, 0, 0, 16, 0, 0, 16'h0000, 0);
      run_txn(8, 8'h10, 0, 8'h05, 0, 0, 15, 0, 0, 16'h9A78, 0);
      run_txn(9, 8'hFF, 0, 0, 8'h05, 0, 3, 0, 6, 0, 0);
      run_txn(10, 8'h20, 0, 0, 0, 16'h10F0, 0, 0, 0, 16'h1110, 1);
      run_txn(4, 8'h67, 8'h45, 0, 0, 0, 0, 1, 0, 16'h4567, 0);
      run_txn(9, 8'h15, 0, 0, 8'h90, 0, 2, 3, 0, 16'h9B08, 1);
      run_txn(0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 16'h0000, 0);
      run_txn(2, 8'hF0, 0, 8'h20, 0, 0, 0, 0, 0, 16'h0010, 0);
      run_txn(3, 8'h01, 0, 0, 8'hFF, 0, 0, 0, 0, 16'h0000, 0);
      run_txn(10, 8'hF0, 0, 0, 0, 16'h1005, 0, 0, 0, 16'h0FF5, 1);
      run_txn(6, 8'hFF, 8'hFF, 0, 8'h01, 0, 0, 0, 0, 16'h0000, 1);
      run_txn(11, 8'h12, 8'h34, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
      run_txn(8, 8'hFE, 0, 8'h01, 0, 0, 1, 0, 0, 16'h30FE, 0);
      run_txn(14, 8'h55, 8'h66, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
      run_txn(1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 16'h0080, 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
